// File: rtl/ahb_master_req_ctrl_pkg.sv
// ahb_master_req_ctrl_pkg: AHB transfer/burst types and burst length helpers
package ahb_master_req_ctrl_pkg;
  typedef enum logic [2:0] {
    SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3,
    WRAP8 = 3'd4, INCR8 = 3'd5, WRAP16 = 3'd6, INCR16 = 3'd7
  } hburst_type;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_type;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BURST, S_TAIL} state_type;
  function automatic logic [4:0] burst_beats(hburst_type b, logic [3:0] len);
    return b == SINGLE ? 5'd1 :
           b == INCR ? {1'b0, len} + 5'd1 :
           b inside {WRAP4, INCR4} ? 5'd4 :
           b inside {WRAP8, INCR8} ? 5'd8 : 5'd16;
  endfunction
  function automatic logic is_wrap(hburst_type b);
    return b inside {WRAP4, WRAP8, WRAP16};
  endfunction
endpackage

// File: rtl/ahb_master_req_ctrl_if.sv
// ahb_master_req_ctrl_if: local command, AHB master bus and local data signals
interface ahb_master_req_ctrl_if
  import ahb_master_req_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int PRIOR_BIT = 1
);
  logic cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr, haddr;
  hburst_type cmd_burst, hburst;
  logic [3:0] cmd_len;
  logic [2:0] cmd_size, hsize;
  logic [PRIOR_BIT-1:0] cmd_prior, hprior;
  logic hreq, hgrant, hwait, hwrite;
  htrans_type htrans;
  logic [DATA_WIDTH-1:0] hwdata, hrdata, wr_data, rd_data;
  logic wr_ready, rd_valid, done;
  modport master (
    input cmd_valid, cmd_addr, cmd_burst, cmd_len, cmd_size, cmd_write, cmd_prior,
    input hgrant, hwait, hrdata, wr_data,
    output cmd_ready, hreq, hprior, htrans, haddr, hburst, hsize, hwrite, hwdata,
    output wr_ready, rd_data, rd_valid, done
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_burst, cmd_len, cmd_size, cmd_write, cmd_prior,
    output hgrant, hwait, hrdata, wr_data,
    input cmd_ready, hreq, hprior, htrans, haddr, hburst, hsize, hwrite, hwdata,
    input wr_ready, rd_data, rd_valid, done
  );
endinterface

// File: rtl/ahb_master_req_ctrl_addr_gen.sv
// ahb_master_req_ctrl_addr_gen: next beat address for incrementing and wrapping bursts
module ahb_master_req_ctrl_addr_gen
  import ahb_master_req_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] haddr_i,
  input  hburst_type            hburst_i,
  input  logic [2:0]            hsize_i,
  output logic [ADDR_WIDTH-1:0] next_o
);
  logic [ADDR_WIDTH-1:0] inc, mask;
  assign inc = haddr_i + (ADDR_WIDTH'(1) << hsize_i);
  // wrap boundary = beats * bytes per beat; only the bits below it move
  assign mask = (ADDR_WIDTH'(burst_beats(hburst_i, 4'd0)) << hsize_i) - ADDR_WIDTH'(1);
  assign next_o = is_wrap(hburst_i) ? (haddr_i & ~mask) | (inc & mask) : inc;
endmodule

// File: rtl/ahb_master_req_ctrl.sv
// ahb_master_req_ctrl: requests the bus, issues one burst and tracks its pipelined data phase
module ahb_master_req_ctrl
  import ahb_master_req_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int PRIOR_BIT = 1
) (
  input logic hclk,
  input logic hreset,
  ahb_master_req_ctrl_if.master bus
);
  state_type state_q;
  logic [ADDR_WIDTH-1:0] addr_q, next_addr;
  hburst_type bt_q, hb_q;
  logic [2:0] size_q;
  logic write_q, first_q, dph_q;
  logic [PRIOR_BIT-1:0] prior_q;
  logic [4:0] left_q;
  logic accept, lost;
  assign accept = (state_q == S_BURST) && bus.hgrant && !bus.hwait;
  assign lost = (state_q == S_BURST) && !bus.hgrant && !bus.hwait;
  // bt_q keeps the original burst for addressing after a regrant re-issues it as INCR
  ahb_master_req_ctrl_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .haddr_i(addr_q), .hburst_i(bt_q), .hsize_i(size_q), .next_o(next_addr)
  );
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      bt_q <= SINGLE;
      hb_q <= SINGLE;
      size_q <= '0;
      write_q <= 1'b0;
      prior_q <= '0;
      left_q <= '0;
      first_q <= 1'b0;
      dph_q <= 1'b0;
    end else begin
      dph_q <= accept || (dph_q && bus.hwait);
      case (state_q)
        S_IDLE: if (bus.cmd_valid) begin
          state_q <= S_REQ;
          addr_q <= bus.cmd_addr;
          bt_q <= bus.cmd_burst;
          hb_q <= bus.cmd_burst;
          size_q <= bus.cmd_size > 3'd2 ? 3'd2 : bus.cmd_size;
          write_q <= bus.cmd_write;
          prior_q <= bus.cmd_prior;
          left_q <= burst_beats(bus.cmd_burst, bus.cmd_len);
        end
        S_REQ: if (bus.hgrant) begin
          state_q <= S_BURST;
          first_q <= 1'b1;
        end
        S_BURST: if (accept) begin
          addr_q <= next_addr;
          left_q <= left_q - 5'd1;
          first_q <= 1'b0;
          if (left_q == 5'd1) state_q <= S_TAIL;
        end else if (lost) begin
          state_q <= S_REQ;
          hb_q <= INCR;
        end
        default: if (!bus.hwait) state_q <= S_IDLE;
      endcase
    end
  end
  assign bus.cmd_ready = state_q == S_IDLE;
  assign bus.hreq = (state_q == S_REQ) || (state_q == S_BURST);
  assign bus.htrans = ((state_q == S_BURST) && (bus.hgrant || bus.hwait)) ? (first_q ? NONSEQ : SEQ) : IDLE;
  assign bus.haddr = addr_q;
  assign bus.hburst = hb_q;
  assign bus.hsize = size_q;
  assign bus.hwrite = write_q;
  assign bus.hprior = prior_q;
  assign bus.hwdata = {DATA_WIDTH{dph_q && write_q}} & bus.wr_data;
  assign bus.wr_ready = dph_q && !bus.hwait && write_q;
  assign bus.rd_valid = dph_q && !bus.hwait && !write_q;
  assign bus.rd_data = bus.hrdata;
  assign bus.done = (state_q == S_TAIL) && !bus.hwait;
endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
// tb_ahb_master_req_ctrl: directed then random commands with random grant/wait against a transaction model
module tb_ahb_master_req_ctrl;
  import ahb_master_req_ctrl_pkg::*;
  logic hclk = 1'b0;
  logic hreset;
  always #5 hclk = ~hclk;
  ahb_master_req_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIOR_BIT(1)) bus ();
  ahb_master_req_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIOR_BIT(1)) dut (
    .hclk(hclk), .hreset(hreset), .bus(bus)
  );
  int vectors = 0, miscompares = 0;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // model: remaining beat addresses of the command in hand plus bus ownership
  logic [31:0] q[$];
  bit m_busy, m_own, m_fresh, m_dph, m_rst_addr, m_write, m_prior;
  hburst_type m_hb;
  logic [2:0] m_size;
  int m_total;
  int beats_tab [8] = '{1, 0, 4, 4, 8, 8, 16, 16};
  function automatic void plan(logic [31:0] start, hburst_type b, logic [3:0] len, logic [2:0] sz);
    int n = b == INCR ? int'(len) + 1 : beats_tab[int'(b)];
    longint unsigned step = 64'd1 << sz;
    longint unsigned bound = longint'(n) * step;
    longint unsigned off = longint'(start) % bound;
    bit wrap = b inside {WRAP4, WRAP8, WRAP16};
    q.delete();
    m_total = n;
    for (int i = 0; i < n; i++)
      q.push_back(wrap ? 32'(longint'(start) - off + (off + longint'(i) * step) % bound)
                       : 32'(longint'(start) + longint'(i) * step));
  endfunction
  task automatic model_reset();
    m_busy = 0; m_own = 0; m_fresh = 0; m_dph = 0; m_rst_addr = 1;
    m_write = 0; m_prior = 0; m_hb = SINGLE; m_size = 0; m_total = 0;
    q.delete();
  endtask
  localparam int ND = 10;
  hburst_type d_burst [ND] = '{SINGLE, INCR4, WRAP4, INCR8, INCR16, SINGLE, INCR, INCR, INCR, WRAP8};
  logic [31:0] d_addr [ND] = '{32'h100, 32'h200, 32'h3C, 32'h200, 32'h400, 32'h100, 32'h500, 32'h600, 32'hFFFF_FFF0, 32'h1014};
  logic [3:0] d_len [ND] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15, 4'd7, 4'd0};
  logic [2:0] d_size [ND] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1};
  bit d_write [ND] = '{1, 0, 1, 0, 1, 1, 0, 1, 0, 0};
  initial begin
    int d_idx;
    bit directed, did_rst, acc, fin, wr_ph, rd_ph;
    logic [2:0] csz;
    htrans_type exp_ht;
    d_idx = 0;
    did_rst = 0;
    hreset = 1'b1;
    bus.cmd_valid = 0; bus.cmd_addr = '0; bus.cmd_burst = SINGLE; bus.cmd_len = '0;
    bus.cmd_size = '0; bus.cmd_write = 0; bus.cmd_prior = '0;
    bus.hgrant = 0; bus.hwait = 0; bus.hrdata = '0; bus.wr_data = '0;
    model_reset();
    repeat (2) @(posedge hclk);
    for (int c = 0; c < 4000; c++) begin
      @(negedge hclk);
      hreset = (d_idx == ND && $urandom_range(0, 149) == 0) ||
               (!did_rst && m_total == 16 && q.size() == 14 && m_own);
      if (hreset && d_idx < ND) did_rst = 1;
      bus.hgrant = $urandom_range(0, 3) != 0;
      bus.hwait = $urandom_range(0, 3) == 0;
      bus.hrdata = $urandom;
      bus.wr_data = $urandom;
      directed = !m_busy && d_idx < ND;
      if (directed) begin
        bus.cmd_valid = 1;
        bus.cmd_burst = d_burst[d_idx];
        bus.cmd_addr = d_addr[d_idx];
        bus.cmd_len = d_len[d_idx];
        bus.cmd_size = d_size[d_idx];
        bus.cmd_write = d_write[d_idx];
        bus.cmd_prior = 1'($urandom);
      end else begin
        bus.cmd_valid = $urandom_range(0, 1) == 1;
        bus.cmd_burst = hburst_type'($urandom_range(0, 7));
        bus.cmd_len = 4'($urandom);
        bus.cmd_size = 3'($urandom_range(0, 3));
        bus.cmd_write = 1'($urandom);
        bus.cmd_prior = 1'($urandom);
        csz = bus.cmd_size > 3'd2 ? 3'd2 : bus.cmd_size;
        bus.cmd_addr = ($urandom_range(0, 3) == 0 ? (32'hFFFF_FFC0 | 32'($urandom_range(0, 63))) : 32'($urandom))
                       & ~((32'd1 << csz) - 32'd1);
      end
      #1;
      chk("cmd_ready", 64'(bus.cmd_ready), 64'(!m_busy));
      chk("hreq", 64'(bus.hreq), 64'(m_busy && q.size() > 0));
      exp_ht = (m_own && (bus.hgrant || bus.hwait)) ? (m_fresh ? NONSEQ : SEQ) : IDLE;
      chk("htrans", 64'(bus.htrans), 64'(exp_ht));
      if (m_busy && q.size() > 0) chk("haddr", 64'(bus.haddr), 64'(q[0]));
      else if (m_rst_addr) chk("haddr_rst", 64'(bus.haddr), 64'd0);
      chk("hburst", 64'(bus.hburst), 64'(m_hb));
      chk("hsize", 64'(bus.hsize), 64'(m_size));
      chk("hwrite", 64'(bus.hwrite), 64'(m_write));
      chk("hprior", 64'(bus.hprior), 64'(m_prior));
      wr_ph = m_dph && !bus.hwait && m_write;
      rd_ph = m_dph && !bus.hwait && !m_write;
      chk("wr_ready", 64'(bus.wr_ready), 64'(wr_ph));
      chk("rd_valid", 64'(bus.rd_valid), 64'(rd_ph));
      if (wr_ph) chk("hwdata", 64'(bus.hwdata), 64'(bus.wr_data));
      if (rd_ph) chk("rd_data", 64'(bus.rd_data), 64'(bus.hrdata));
      chk("done", 64'(bus.done), 64'(m_busy && q.size() == 0 && !bus.hwait));
      @(posedge hclk);
      if (hreset) model_reset();
      else begin
        acc = m_own && bus.hgrant && !bus.hwait;
        fin = m_busy && q.size() == 0 && !bus.hwait;
        m_dph = acc || (m_dph && bus.hwait);
        if (!m_busy) begin
          if (bus.cmd_valid) begin
            m_busy = 1; m_own = 0; m_rst_addr = 0;
            m_hb = bus.cmd_burst;
            m_size = bus.cmd_size > 3'd2 ? 3'd2 : bus.cmd_size;
            m_write = bus.cmd_write;
            m_prior = bus.cmd_prior;
            plan(bus.cmd_addr, bus.cmd_burst, bus.cmd_len, m_size);
            if (directed) d_idx++;
          end
        end else if (fin) m_busy = 0;
        else if (acc) begin
          void'(q.pop_front());
          m_fresh = 0;
          if (q.size() == 0) m_own = 0;
        end else if (m_own && !bus.hgrant && !bus.hwait) begin
          m_own = 0;
          m_hb = INCR;
        end else if (!m_own && q.size() > 0 && bus.hgrant) begin
          m_own = 1;
          m_fresh = 1;
        end
      end
    end
    chk("directed_cmds_issued", 64'(d_idx), 64'(ND));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
